note_lane_scheduler: RTL and testbench

//  Two-lane note scheduler. Spawns falling blocks from a fixed beat pattern and scrolls them
//  one step per scroll tick. Drives block1_bot/block2_bot into linecheck.

---
 rtl/note_lane_scheduler_if.sv | 32 +++
 rtl/note_lane_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_note_lane_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/note_lane_scheduler_if.sv
// Scheduler <-> game FSM / judge / linecheck bundle.
// Latency: n/a (wires only); the scheduler registers every output it drives here.
// Backpressure: none; pause is the only stall and lives on this bundle.
interface note_lane_scheduler_if;
  logic       start;
  logic       pause;
  logic       hit1;
  logic       hit2;
  logic [9:0] block1_bot;
  logic [9:0] block2_bot;
  logic       block1_active;
  logic       block2_active;
  logic       miss1;
  logic       miss2;
  logic [3:0] beat_idx;
  logic       done;
  logic [1:0] state;

  // Game FSM / judge / bench side: drives controls and hits, observes lanes.
  modport master (
    output start, pause, hit1, hit2,
    input  block1_bot, block2_bot, block1_active, block2_active,
    input  miss1, miss2, beat_idx, done, state
  );

  // Scheduler side.
  modport slave (
    input  start, pause, hit1, hit2,
    output block1_bot, block2_bot, block1_active, block2_active,
    output miss1, miss2, beat_idx, done, state
  );
endinterface

// File: rtl/note_lane_scheduler.sv
// Two-lane falling-note scheduler: spawns from beat masks, scrolls per tick, retires on hit/miss.
// Latency: all outputs registered; a hit or tick shows on the outputs one cycle after it is sampled.
// Backpressure: none; pause freezes counters and positions, and hits are dropped while paused.
module note_lane_scheduler #(
  parameter int          TICK_DIV    = 250000,
  parameter int          STEP        = 5,
  parameter int          SPAWN_Y     = 0,
  parameter int          BOTTOM      = 480,
  parameter int          BEAT_STEPS  = 20,
  parameter int          PATTERN_LEN = 16,
  parameter logic [15:0] PATTERN1    = 16'hA5A5,
  parameter logic [15:0] PATTERN2    = 16'h5A5A
) (
  input  logic                   clk,
  input  logic                   reset,
  note_lane_scheduler_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BEAT_STEPS > 1) ? $clog2(BEAT_STEPS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_STEPS - 1);
  // beat_idx must be able to sit at PATTERN_LEN (up to 16), so it is kept one bit wider
  // internally than the 4-bit port; with a 16-beat song the port reads 0 once saturated.
  localparam logic [4:0]    LEN5      = 5'(PATTERN_LEN);

  typedef struct packed {
    logic       act;
    logic [9:0] bot;
    logic       miss;
  } lane_t;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [4:0]    idx_q, idx_d;
  logic          act1_q, act1_d, act2_q, act2_d;
  logic [9:0]    bot1_q, bot1_d, bot2_q, bot2_d;
  logic          miss1_q, miss1_d, miss2_q, miss2_d;
  logic          done_q, done_d;

  logic          tick;
  logic          beat_issue;
  logic          spawn1;
  logic          spawn2;
  lane_t         lane1;
  lane_t         lane2;

  // Hit first, then advance on a tick, then spawn into a lane that is free afterwards.
  function automatic lane_t lane_step(input logic act, input logic [9:0] bot, input logic hit,
                                      input logic do_tick, input logic spawn);
    lane_t       r;
    logic [10:0] sum;
    r.act  = act;
    r.bot  = bot;
    r.miss = 1'b0;
    sum    = '0;
    if (hit && r.act) begin
      r.act = 1'b0;
      r.bot = '0;
    end
    if (do_tick) begin
      if (r.act) begin
        sum = {1'b0, r.bot} + 11'(STEP);
        if (sum >= 11'(BOTTOM)) begin
          r.act  = 1'b0;
          r.bot  = '0;
          r.miss = 1'b1;
        end else begin
          r.bot = sum[9:0];
        end
      end
      if (spawn && !r.act) begin
        r.act = 1'b1;
        r.bot = 10'(SPAWN_Y);
      end
    end
    return r;
  endfunction

  assign tick       = (tick_q == TICK_LAST);
  assign beat_issue = (beat_q == '0) && (idx_q < LEN5);
  assign spawn1     = beat_issue && PATTERN1[idx_q[3:0]];
  assign spawn2     = beat_issue && PATTERN2[idx_q[3:0]];

  // Next-state: game FSM, scroll/beat counters and both lanes.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    act1_d  = act1_q;
    act2_d  = act2_q;
    bot1_d  = bot1_q;
    bot2_d  = bot2_q;
    miss1_d = 1'b0;
    miss2_d = 1'b0;
    done_d  = done_q;
    lane1   = lane_step(act1_q, bot1_q, bus.hit1, tick, spawn1);
    lane2   = lane_step(act2_q, bot2_q, bus.hit2, tick, spawn2);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          tick_d  = '0;
          beat_d  = '0;
          idx_d   = '0;
          act1_d  = 1'b0;
          act2_d  = 1'b0;
          bot1_d  = '0;
          bot2_d  = '0;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.pause) begin
          // The pausing cycle itself is frozen so the tick phase is preserved exactly.
          state_d = ST_PAUSED;
        end else begin
          tick_d  = tick ? '0 : tick_q + 1'b1;
          if (tick) begin
            beat_d = (beat_q == BEAT_LAST) ? '0 : beat_q + 1'b1;
            if (beat_issue) idx_d = idx_q + 1'b1;
          end
          act1_d  = lane1.act;
          bot1_d  = lane1.bot;
          miss1_d = lane1.miss;
          act2_d  = lane2.act;
          bot2_d  = lane2.bot;
          miss2_d = lane2.miss;
          if ((idx_d == LEN5) && !lane1.act && !lane2.act) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        if (!bus.pause) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts the song outright without emitting misses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      act1_q  <= 1'b0;
      act2_q  <= 1'b0;
      bot1_q  <= '0;
      bot2_q  <= '0;
      miss1_q <= 1'b0;
      miss2_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      act1_q  <= act1_d;
      act2_q  <= act2_d;
      bot1_q  <= bot1_d;
      bot2_q  <= bot2_d;
      miss1_q <= miss1_d;
      miss2_q <= miss2_d;
      done_q  <= done_d;
    end
  end

  assign bus.block1_bot    = bot1_q;
  assign bus.block2_bot    = bot2_q;
  assign bus.block1_active = act1_q;
  assign bus.block2_active = act2_q;
  assign bus.miss1         = miss1_q;
  assign bus.miss2         = miss2_q;
  assign bus.beat_idx      = idx_q[3:0];
  assign bus.done          = done_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Directed bench for note_lane_scheduler with a short song (TICK_DIV=4, BEAT_STEPS=2, 4 beats).
// Latency: checks sample 1 time unit after the rising edge that registered the result.
// Backpressure: n/a; pause is exercised as a directed stall.
module tb_note_lane_scheduler;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  note_lane_scheduler_if bus ();

  note_lane_scheduler #(
    .TICK_DIV    (4),
    .STEP        (5),
    .SPAWN_Y     (0),
    .BOTTOM      (20),
    .BEAT_STEPS  (2),
    .PATTERN_LEN (4),
    .PATTERN1    (16'h0003),
    .PATTERN2    (16'h0004)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_lanes(input string tag, input logic a1, input int b1,
                             input logic a2, input int b2);
    check({tag, ".act1"}, 32'(bus.block1_active), 32'(a1));
    check({tag, ".bot1"}, 32'(bus.block1_bot), 32'(b1));
    check({tag, ".act2"}, 32'(bus.block2_active), 32'(a2));
    check({tag, ".bot2"}, 32'(bus.block2_bot), 32'(b2));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".state"}, 32'(bus.state), 32'd0);
    check({tag, ".done"}, 32'(bus.done), 32'd0);
    check({tag, ".miss1"}, 32'(bus.miss1), 32'd0);
    check({tag, ".miss2"}, 32'(bus.miss2), 32'd0);
    check({tag, ".beat"}, 32'(bus.beat_idx), 32'd0);
    check_lanes(tag, 1'b0, 0, 1'b0, 0);
  endtask

  // Start is sampled on edge E0; ticks then land on E4, E8, E12, ...
  task automatic start_song();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.hit1  = 1'b0;
    bus.hit2  = 1'b0;

    // Reset state
    step(3);
    reset = 1'b1;
    check_idle("rst");
    step(2);
    check_idle("idle_hold");

    // Song without hits
    start_song();
    check("s2.run", 32'(bus.state), 32'd1);
    step(4);                                     // E4: tick 1, beat 0 spawns lane 1
    check_lanes("s2.t1", 1'b1, 0, 1'b0, 0);
    check("s2.t1.beat", 32'(bus.beat_idx), 32'd1);
    step(4);                                     // E8
    check_lanes("s2.t2", 1'b1, 5, 1'b0, 0);
    bus.hit2 = 1'b1;                             // lane 2 inactive: no effect
    step(1);                                     // E9
    bus.hit2 = 1'b0;
    check_lanes("s5.hit2_idle", 1'b1, 5, 1'b0, 0);
    check("s5.hit2_idle.miss2", 32'(bus.miss2), 32'd0);
    step(3);                                     // E12: beat-1 spawn dropped
    check_lanes("s2.t3", 1'b1, 10, 1'b0, 0);
    check("s2.t3.beat", 32'(bus.beat_idx), 32'd2);
    step(4);                                     // E16
    check_lanes("s2.t4", 1'b1, 15, 1'b0, 0);
    check("s2.t4.miss1", 32'(bus.miss1), 32'd0);
    step(4);                                     // E20: lane 1 misses, lane 2 spawns
    check("s2.t5.miss1", 32'(bus.miss1), 32'd1);
    check_lanes("s2.t5", 1'b0, 0, 1'b1, 0);
    check("s2.t5.beat", 32'(bus.beat_idx), 32'd3);
    step(1);
    check("s2.miss1_pulse", 32'(bus.miss1), 32'd0);
    step(14);                                    // E35: lane 2 still on screen at 15
    check_lanes("s2.pre_done", 1'b0, 0, 1'b1, 15);
    check("s2.pre_done.state", 32'(bus.state), 32'd1);
    check("s2.pre_done.done", 32'(bus.done), 32'd0);
    check("s2.pre_done.beat", 32'(bus.beat_idx), 32'd4);
    step(1);                                     // E36: lane 2 misses, song over
    check("s5.done", 32'(bus.done), 32'd1);
    check("s5.state", 32'(bus.state), 32'd3);
    check("s5.miss2", 32'(bus.miss2), 32'd1);
    check_lanes("s5.done", 1'b0, 0, 1'b0, 0);
    bus.pause = 1'b1;                            // ignored in DONE
    step(2);
    check("s5.done_pause.state", 32'(bus.state), 32'd3);
    bus.pause = 1'b0;
    start_song();
    check("s5.restart.state", 32'(bus.state), 32'd1);
    check("s5.restart.beat", 32'(bus.beat_idx), 32'd0);
    check("s5.restart.done", 32'(bus.done), 32'd0);

    // Hit on the same cycle as tick 3
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    check_idle("s3.rst");
    start_song();
    step(11);                                    // E11
    check_lanes("s3.pre_hit", 1'b1, 5, 1'b0, 0);
    bus.hit1 = 1'b1;
    step(1);                                     // E12: hit, then beat-1 spawn accepted
    bus.hit1 = 1'b0;
    check_lanes("s3.hit", 1'b1, 0, 1'b0, 0);
    check("s3.hit.miss1", 32'(bus.miss1), 32'd0);
    check("s3.hit.beat", 32'(bus.beat_idx), 32'd2);
    step(4);                                     // E16
    check_lanes("s3.t4", 1'b1, 5, 1'b0, 0);

    // Pause for 50 cycles (E17..E66); hits during pause dropped
    bus.pause = 1'b1;
    step(1);                                     // E17
    check("s4.paused", 32'(bus.state), 32'd2);
    bus.hit1 = 1'b1;
    bus.hit2 = 1'b1;
    step(1);                                     // E18
    bus.hit1 = 1'b0;
    bus.hit2 = 1'b0;
    check_lanes("s4.hit_paused", 1'b1, 5, 1'b0, 0);
    step(48);                                    // E66
    check("s4.hold.state", 32'(bus.state), 32'd2);
    check_lanes("s4.hold", 1'b1, 5, 1'b0, 0);
    check("s4.hold.beat", 32'(bus.beat_idx), 32'd2);
    bus.pause = 1'b0;
    step(4);                                     // E70: back in RUN, tick not yet due
    check("s4.resume.state", 32'(bus.state), 32'd1);
    check_lanes("s4.resume", 1'b1, 5, 1'b0, 0);
    step(1);                                     // E71: deferred tick 5
    check_lanes("s4.t5", 1'b1, 10, 1'b1, 0);
    check("s4.t5.beat", 32'(bus.beat_idx), 32'd3);
    step(4);                                     // E75
    check_lanes("s6.pre_rst", 1'b1, 15, 1'b1, 5);

    // Reset mid-song with both lanes active
    reset = 1'b0;
    step(1);
    check_idle("s6.rst");
    reset = 1'b1;
    step(2);
    check_idle("s6.after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
